// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 protocol bytes and command sequencer state encoding
package ps2_pkg;

  localparam logic [7:0] PS2_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_ERROR   = 8'hFC;
  localparam logic [7:0] PS2_ECHO    = 8'hEE;
  localparam logic [7:0] PS2_SET_LED = 8'hED;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_BUS = 3'd1;
  localparam logic [2:0] SEND     = 3'd2;
  localparam logic [2:0] WAIT_TX  = 3'd3;
  localparam logic [2:0] WAIT_ACK = 3'd4;
  localparam logic [2:0] DONE_OK  = 3'd5;
  localparam logic [2:0] DONE_ERR = 3'd6;

  localparam logic PH_CMD = 1'b0;
  localparam logic PH_ARG = 1'b1;

  // Bytes the sequencer consumes while awaiting a reply; anything else is forwarded.
  function automatic logic is_reply(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_RESEND) || (b == PS2_ERROR);
  endfunction

endpackage

// File: rtl/ps2_timeout_counter.sv
// rtl/ps2_timeout_counter.sv - saturating cycle counter with clear/enable and a hit flag
module ps2_timeout_counter #(
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic ck,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);
  localparam logic [W-1:0] LAST  = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] count;

  always_ff @(posedge ck) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  // Hit fires on the TIMEOUT_CYC-th enabled cycle after a clear.
  assign hit = en && (count == LAST);

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// rtl/ps2_cmd_sequencer.sv - PS/2 host command sender with ACK/RESEND/ERROR handling and byte forwarding
module ps2_cmd_sequencer
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       cmd_req,
  input  logic [7:0] cmd_byte,
  input  logic [7:0] arg_byte,
  input  logic       arg_en,
  output logic       cmd_busy,
  output logic       cmd_done,
  output logic       cmd_err,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_busy,
  output logic       key_valid,
  output logic [7:0] key_data
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  logic [2:0]    state;
  logic [2:0]    next_state;
  logic          phase;
  logic [RW-1:0] retry;
  logic [7:0]    cmd_q;
  logic [7:0]    arg_q;
  logic          arg_en_q;
  logic          tx_seen;
  logic          attempt_fail;
  logic          arg_advance;
  logic          tmo_hit;
  logic          tmo_en;
  logic          tmo_clr;
  logic          consume_rx;

  assign tmo_en     = (state == WAIT_TX) || (state == WAIT_ACK);
  assign tmo_clr    = reset || (next_state != state);
  assign consume_rx = (state == WAIT_ACK) && is_reply(rx_data);

  ps2_timeout_counter #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .ck  (ck),
    .clr (tmo_clr),
    .en  (tmo_en),
    .hit (tmo_hit)
  );

  always_comb begin
    next_state   = state;
    attempt_fail = 1'b0;
    arg_advance  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_req) next_state = WAIT_BUS;
      end
      WAIT_BUS: begin
        if (!rx_busy) next_state = SEND;
      end
      SEND: begin
        next_state = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_seen && !tx_busy) begin
          next_state = WAIT_ACK;
        end else if (tmo_hit) begin
          attempt_fail = 1'b1;
        end
      end
      WAIT_ACK: begin
        // A reply byte takes priority over a timeout landing in the same cycle.
        if (rx_valid) begin
          if (rx_data == PS2_ACK) begin
            if ((phase == PH_CMD) && arg_en_q) begin
              arg_advance = 1'b1;
              next_state  = WAIT_BUS;
            end else begin
              next_state = DONE_OK;
            end
          end else if (rx_data == PS2_RESEND) begin
            attempt_fail = 1'b1;
          end else if (rx_data == PS2_ERROR) begin
            next_state = DONE_ERR;
          end
        end else if (tmo_hit) begin
          attempt_fail = 1'b1;
        end
      end
      DONE_OK:  next_state = IDLE;
      DONE_ERR: next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    if (attempt_fail) begin
      next_state = (retry < RETRY_LIMIT) ? WAIT_BUS : DONE_ERR;
    end
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= PH_CMD;
      retry     <= '0;
      cmd_q     <= '0;
      arg_q     <= '0;
      arg_en_q  <= 1'b0;
      tx_seen   <= 1'b0;
      cmd_busy  <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_err   <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      key_valid <= 1'b0;
      key_data  <= '0;
    end else begin
      state    <= next_state;
      cmd_busy <= (next_state != IDLE);
      cmd_done <= (state == DONE_OK) || (state == DONE_ERR);
      cmd_err  <= (state == DONE_ERR);
      tx_start <= (next_state == SEND);

      if (next_state == SEND) begin
        tx_data <= (phase == PH_ARG) ? arg_q : cmd_q;
      end

      if ((state == IDLE) && cmd_req) begin
        cmd_q    <= cmd_byte;
        arg_q    <= arg_byte;
        arg_en_q <= arg_en;
        phase    <= PH_CMD;
        retry    <= '0;
      end else if (arg_advance) begin
        phase <= PH_ARG;
        retry <= '0;
      end else if (attempt_fail && (retry < RETRY_LIMIT)) begin
        retry <= retry + 1'b1;
      end

      // The writer may raise tx_busy a cycle late, so completion needs a seen-high edge first.
      if (state == SEND) begin
        tx_seen <= 1'b0;
      end else if ((state == WAIT_TX) && tx_busy) begin
        tx_seen <= 1'b1;
      end

      key_valid <= rx_valid && !consume_rx;
      if (rx_valid && !consume_rx) begin
        key_data <= rx_data;
      end
    end
  end

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// tb/tb_ps2_cmd_sequencer.sv - randomized self-checking bench for ps2_cmd_sequencer
module tb_ps2_cmd_sequencer;
  import ps2_pkg::*;

  localparam int TIMEOUT     = 200;
  localparam int RETRIES     = 3;
  localparam int TX_BUSY_CYC = 20;
  localparam int R_ACK = 0, R_RESEND = 1, R_ERR = 2, R_NONE = 3, R_KEY_ACK = 4;

  logic       ck = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_req = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic [7:0] arg_byte = 8'h00;
  logic       arg_en = 1'b0;
  logic       cmd_busy, cmd_done, cmd_err, tx_start, key_valid;
  logic [7:0] tx_data, key_data;
  logic       tx_busy = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_busy = 1'b0;

  always #5 ck = ~ck;

  ps2_cmd_sequencer #(.TIMEOUT_CYC(TIMEOUT), .MAX_RETRY(RETRIES)) dut (
    .ck(ck), .reset(reset), .cmd_req(cmd_req), .cmd_byte(cmd_byte), .arg_byte(arg_byte),
    .arg_en(arg_en), .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_err(cmd_err),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_busy(rx_busy), .key_valid(key_valid), .key_data(key_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  int         script [8];
  int         script_gen = 0;
  logic [7:0] inject_byte = 8'h00;
  int         inject_gen = 0;

  // Writer and device model: writer busy for TX_BUSY_CYC cycles, device answers per script.
  initial begin : bfm
    int busy_cnt;
    int seen_gen;
    int seen_inj;
    int sidx;
    int r;
    int d;
    int due_q[$];
    logic [7:0] byte_q[$];
    busy_cnt = 0; seen_gen = 0; seen_inj = 0; sidx = 0;
    forever begin
      @(posedge ck); #1;
      rx_valid = 1'b0;
      if (reset) begin
        busy_cnt = 0;
        tx_busy = 1'b0;
        due_q.delete();
        byte_q.delete();
      end else begin
        if (script_gen != seen_gen) begin seen_gen = script_gen; sidx = 0; end
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            tx_busy = 1'b0;
            r = (sidx < 8) ? script[sidx] : R_NONE;
            sidx++;
            d = $urandom_range(3, 8);
            case (r)
              R_ACK:     begin due_q.push_back(cyc + d); byte_q.push_back(PS2_ACK); end
              R_RESEND:  begin due_q.push_back(cyc + d); byte_q.push_back(PS2_RESEND); end
              R_ERR:     begin due_q.push_back(cyc + d); byte_q.push_back(PS2_ERROR); end
              R_KEY_ACK: begin
                due_q.push_back(cyc + d);     byte_q.push_back(8'h1C);
                due_q.push_back(cyc + d + 3); byte_q.push_back(PS2_ACK);
              end
              default: ;
            endcase
          end
        end else if (tx_start) begin
          tx_busy = 1'b1;
          busy_cnt = TX_BUSY_CYC;
        end
        if (inject_gen != seen_inj) begin
          seen_inj = inject_gen;
          due_q.push_back(cyc);
          byte_q.push_back(inject_byte);
        end
        if ((due_q.size() > 0) && (due_q[0] <= cyc)) begin
          rx_valid = 1'b1;
          rx_data  = byte_q[0];
          void'(due_q.pop_front());
          void'(byte_q.pop_front());
        end
      end
    end
  end

  logic [7:0] got_tx[$];
  int         tx_cyc[$];
  logic [7:0] got_key[$];
  int         done_cnt = 0;
  logic       last_err = 1'b0;
  int         done_cyc = 0;
  int         last_rx_cyc = 0;
  int         mon_bad = 0;
  logic       prev_rx_valid = 1'b0;
  logic [7:0] prev_rx_data = 8'h00;
  logic       prev_busy = 1'b0;

  always @(negedge ck) begin
    if (tx_start) begin got_tx.push_back(tx_data); tx_cyc.push_back(cyc); end
    if (key_valid) begin
      got_key.push_back(key_data);
      if (!(prev_rx_valid && (prev_rx_data == key_data))) mon_bad <= mon_bad + 1;
    end
    if (cmd_done) begin
      done_cnt <= done_cnt + 1;
      last_err <= cmd_err;
      done_cyc <= cyc;
      if (cmd_busy || !prev_busy) mon_bad <= mon_bad + 1;
    end else if (cmd_err) begin
      mon_bad <= mon_bad + 1;
    end
    if (rx_valid) last_rx_cyc <= cyc;
    prev_rx_valid <= rx_valid;
    prev_rx_data  <= rx_data;
    prev_busy     <= cmd_busy;
  end

  logic [7:0] exp_tx[$];
  logic [7:0] exp_key[$];
  logic       exp_err;
  int         base_tx, base_key, base_done;

  // Reference: each byte gets up to RETRIES+1 sends; ACK advances, FC aborts, FE/silence retries.
  function automatic void model(input logic [7:0] c, input logic [7:0] a, input logic ae);
    int idx;
    int tries;
    int r;
    logic ok;
    exp_tx.delete();
    exp_key.delete();
    exp_err = 1'b0;
    idx = 0;
    for (int b = 0; b < (ae ? 2 : 1); b++) begin
      tries = 0;
      ok = 1'b0;
      while (!ok && !exp_err) begin
        exp_tx.push_back((b == 0) ? c : a);
        r = (idx < 8) ? script[idx] : R_NONE;
        idx++;
        if ((r == R_ACK) || (r == R_KEY_ACK)) begin
          if (r == R_KEY_ACK) exp_key.push_back(8'h1C);
          ok = 1'b1;
        end else if (r == R_ERR) begin
          exp_err = 1'b1;
        end else begin
          tries++;
          if (tries > RETRIES) exp_err = 1'b1;
        end
      end
      if (exp_err) break;
    end
  endfunction

  task automatic start_cmd(input logic [7:0] c, input logic [7:0] a, input logic ae);
    model(c, a, ae);
    base_tx   = got_tx.size();
    base_key  = got_key.size();
    base_done = done_cnt;
    script_gen++;
    @(posedge ck); #1;
    cmd_req = 1'b1; cmd_byte = c; arg_byte = a; arg_en = ae;
    @(posedge ck); #1;
    cmd_req = 1'b0; cmd_byte = $urandom(); arg_byte = $urandom(); arg_en = $urandom();
    check("busy_on_accept", 32'(cmd_busy), 32'd1);
  endtask

  task automatic finish_cmd(input string tag);
    int n;
    int nt;
    int nk;
    n = 0;
    while ((done_cnt == base_done) && (n < 4000)) begin @(posedge ck); n++; end
    check({tag, ".done_seen"}, 32'(done_cnt != base_done), 32'd1);
    repeat (5) @(posedge ck);
    #1;
    check({tag, ".done_count"}, 32'(done_cnt - base_done), 32'd1);
    check({tag, ".err"}, 32'(last_err), 32'(exp_err));
    nt = got_tx.size() - base_tx;
    check({tag, ".tx_count"}, 32'(nt), 32'(exp_tx.size()));
    for (int i = 0; (i < nt) && (i < exp_tx.size()); i++)
      check({tag, ".tx_data"}, 32'(got_tx[base_tx + i]), 32'(exp_tx[i]));
    nk = got_key.size() - base_key;
    check({tag, ".key_count"}, 32'(nk), 32'(exp_key.size()));
    for (int i = 0; (i < nk) && (i < exp_key.size()); i++)
      check({tag, ".key_data"}, 32'(got_key[base_key + i]), 32'(exp_key[i]));
    if (!exp_err) check({tag, ".ack_to_done"}, 32'(done_cyc - last_rx_cyc), 32'd2);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".cmd_busy"},  32'(cmd_busy),  32'd0);
    check({tag, ".cmd_done"},  32'(cmd_done),  32'd0);
    check({tag, ".cmd_err"},   32'(cmd_err),   32'd0);
    check({tag, ".tx_start"},  32'(tx_start),  32'd0);
    check({tag, ".key_valid"}, 32'(key_valid), 32'd0);
    check({tag, ".tx_data"},   32'(tx_data),   32'd0);
    check({tag, ".key_data"},  32'(key_data),  32'd0);
  endtask

  initial begin
    int n;
    int kb;
    int snap_done;
    int snap_tx;
    for (int i = 0; i < 8; i++) script[i] = R_NONE;
    repeat (3) @(posedge ck);
    #1;
    check_quiet("reset");
    reset = 1'b0;
    repeat (2) @(posedge ck);

    script = '{R_ACK, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE};
    start_cmd(PS2_ECHO, 8'h00, 1'b0);
    finish_cmd("echo_ack");

    script = '{R_ACK, R_ACK, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE};
    start_cmd(PS2_SET_LED, 8'h02, 1'b1);
    finish_cmd("led_arg");

    script = '{R_RESEND, R_ACK, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE};
    start_cmd(PS2_ECHO, 8'h00, 1'b0);
    finish_cmd("resend_once");

    script = '{R_RESEND, R_RESEND, R_RESEND, R_RESEND, R_RESEND, R_RESEND, R_RESEND, R_RESEND};
    start_cmd(PS2_ECHO, 8'h00, 1'b0);
    finish_cmd("resend_all");

    script = '{R_NONE, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE};
    start_cmd(PS2_ECHO, 8'h00, 1'b0);
    finish_cmd("silent");
    for (int i = 1; (i < 4) && (base_tx + i < got_tx.size()); i++)
      check("silent.spacing", 32'(tx_cyc[base_tx + i] - tx_cyc[base_tx + i - 1]),
            32'(2 + TX_BUSY_CYC + TIMEOUT));

    script = '{R_ERR, R_ACK, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE};
    start_cmd(PS2_ECHO, 8'h00, 1'b0);
    finish_cmd("error_fc");

    script = '{R_KEY_ACK, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE};
    start_cmd(PS2_ECHO, 8'h00, 1'b0);
    finish_cmd("key_in_ack");

    kb = got_key.size();
    inject_byte = 8'h1C;
    inject_gen++;
    repeat (6) @(posedge ck);
    #1;
    check("idle_key.count", 32'(got_key.size() - kb), 32'd1);
    if (got_key.size() > kb) check("idle_key.data", 32'(got_key[kb]), 32'h1C);

    script = '{R_ACK, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE};
    rx_busy = 1'b1;
    start_cmd(PS2_ECHO, 8'h00, 1'b0);
    repeat (30) @(posedge ck);
    #1;
    check("rx_busy.hold", 32'(got_tx.size() - base_tx), 32'd0);
    rx_busy = 1'b0;
    finish_cmd("rx_busy");

    script = '{R_NONE, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE};
    start_cmd(PS2_ECHO, 8'h00, 1'b0);
    n = 0;
    while ((got_tx.size() == base_tx) && (n < 100)) begin @(posedge ck); n++; end
    check("abort.first_tx", 32'(got_tx.size() - base_tx), 32'd1);
    repeat (40) @(posedge ck);
    #1 reset = 1'b1;
    @(posedge ck);
    #1;
    check_quiet("abort");
    reset = 1'b0;
    snap_done = done_cnt;
    snap_tx = got_tx.size();
    repeat (300) @(posedge ck);
    #1;
    check("abort.no_done", 32'(done_cnt - snap_done), 32'd0);
    check("abort.no_tx", 32'(got_tx.size() - snap_tx), 32'd0);
    script = '{R_ACK, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE};
    start_cmd(PS2_ECHO, 8'h00, 1'b0);
    finish_cmd("after_abort");

    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 8; i++) begin
        n = $urandom_range(0, 9);
        script[i] = (n < 4) ? R_ACK : (n < 6) ? R_RESEND : (n == 6) ? R_ERR :
                    (n == 7) ? R_NONE : R_KEY_ACK;
      end
      start_cmd(8'($urandom()), 8'($urandom()), 1'($urandom()));
      finish_cmd("random");
      repeat ($urandom_range(0, 10)) @(posedge ck);
    end

    check("monitor_violations", 32'(mon_bad), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
